// File: rtl/uart_axil_responder.sv
// AXI4-Lite responder for a 16550-style UART register subset, with TX/RX byte
// FIFOs streamed to/from a serializer core and a level-sensitive interrupt.
module uart_axil_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int BASE_BIT   = 12
) (
  input  logic        chipset_clk,
  input  logic        chipset_rst,
  input  logic [12:0] uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  input  logic [12:0] uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        uart_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic reg_ok(input logic base_hit, input logic [6:0] mid,
                                  input logic [2:0] idx);
    return base_hit && (mid == 7'd0) && (idx != 3'd4) && (idx != 3'd6);
  endfunction

  // Write-path holding registers and response
  logic        aw_held_reg;
  logic [12:0] aw_addr_reg;
  logic        w_held_reg;
  logic [7:0]  w_data_reg;
  logic        bvalid_reg;
  logic [1:0]  bresp_reg;

  // Read-path response
  logic        rvalid_reg;
  logic [7:0]  rdata_reg;
  logic [1:0]  rresp_reg;

  // Register file
  logic [1:0]  ier_reg;
  logic [7:0]  lcr_reg;
  logic [7:0]  scr_reg;
  logic        irq_reg;

  // FIFO index 0 is TX, index 1 is RX
  logic [1:0]         fifo_push;
  logic [1:0]         fifo_pop;
  logic [1:0]         fifo_clr;
  logic [1:0][7:0]    fifo_wdata;
  logic [1:0][7:0]    fifo_head;
  logic [1:0][CW-1:0] fifo_count;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic wr_fire, wr_ok, rd_fire, rd_ok;
  logic [2:0] wr_idx, rd_idx;
  logic thr_wr, ier_wr, fcr_wr, lcr_wr, scr_wr, rbr_rd;
  logic tx_pop, tx_push, rx_push, rx_pop;
  logic [7:0] lsr, iir, rd_byte;
  logic [1:0] rd_resp;
  logic       unused_bits;

  assign tx_empty = (fifo_count[0] == '0);
  assign tx_full  = (fifo_count[0] == FULL_COUNT);
  assign rx_empty = (fifo_count[1] == '0);
  assign rx_full  = (fifo_count[1] == FULL_COUNT);

  // A write executes only once both beats are held and the previous B is gone.
  assign wr_fire = aw_held_reg && w_held_reg && !bvalid_reg;
  assign wr_idx  = aw_addr_reg[4:2];
  assign wr_ok   = reg_ok(aw_addr_reg[BASE_BIT], aw_addr_reg[11:5], wr_idx);
  assign thr_wr  = wr_fire && wr_ok && (wr_idx == 3'd0);
  assign ier_wr  = wr_fire && wr_ok && (wr_idx == 3'd1);
  assign fcr_wr  = wr_fire && wr_ok && (wr_idx == 3'd2);
  assign lcr_wr  = wr_fire && wr_ok && (wr_idx == 3'd3);
  assign scr_wr  = wr_fire && wr_ok && (wr_idx == 3'd7);

  assign rd_fire = uart_axi_arvalid && !rvalid_reg;
  assign rd_idx  = uart_axi_araddr[4:2];
  assign rd_ok   = reg_ok(uart_axi_araddr[BASE_BIT], uart_axi_araddr[11:5], rd_idx);
  assign rbr_rd  = rd_fire && rd_ok && (rd_idx == 3'd0);

  // A full TX FIFO still accepts a THR byte when the serializer pops the same cycle.
  assign tx_pop  = !tx_empty && tx_ready;
  assign tx_push = thr_wr && (!tx_full || tx_pop);
  assign rx_push = rx_valid && !rx_full;
  assign rx_pop  = rbr_rd && !rx_empty;

  assign fifo_push  = {rx_push, tx_push};
  assign fifo_pop   = {rx_pop, tx_pop};
  assign fifo_clr   = {fcr_wr && w_data_reg[1], fcr_wr && w_data_reg[2]};
  assign fifo_wdata = {rx_data, w_data_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;

      always_ff @(posedge chipset_clk) begin
        if (fifo_push[gi]) mem[wr_ptr_reg] <= fifo_wdata[gi];
      end

      always_ff @(posedge chipset_clk) begin
        if (chipset_rst || fifo_clr[gi]) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + PW'(1);
          case ({fifo_push[gi], fifo_pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      // Head is read combinationally so tx_data follows the FIFO with no bubble.
      assign fifo_head[gi]  = mem[rd_ptr_reg];
      assign fifo_count[gi] = count_reg;
    end
  endgenerate

  assign lsr = {1'b0, tx_empty, tx_empty, 4'b0000, !rx_empty};
  assign iir = (ier_reg[0] && !rx_empty) ? 8'hC4 :
               (ier_reg[1] && tx_empty)  ? 8'hC2 : 8'hC1;

  always_comb begin
    rd_byte = 8'd0;
    rd_resp = RESP_SLVERR;
    if (rd_ok) begin
      rd_resp = RESP_OKAY;
      case (rd_idx)
        3'd0:    rd_byte = rx_empty ? 8'd0 : fifo_head[1];
        3'd1:    rd_byte = {6'd0, ier_reg};
        3'd2:    rd_byte = iir;
        3'd3:    rd_byte = lcr_reg;
        3'd5:    rd_byte = lsr;
        3'd7:    rd_byte = scr_reg;
        default: rd_byte = 8'd0;
      endcase
    end
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      aw_held_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (wr_fire) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (uart_axi_awvalid && !aw_held_reg) begin
          aw_held_reg <= 1'b1;
          aw_addr_reg <= uart_axi_awaddr;
        end
        if (uart_axi_wvalid && !w_held_reg) begin
          w_held_reg <= 1'b1;
          w_data_reg <= uart_axi_wdata[7:0];
        end
        if (bvalid_reg && uart_axi_bready) bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (rd_fire) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_byte;
      rresp_reg  <= rd_resp;
    end else if (rvalid_reg && uart_axi_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      ier_reg <= 2'b00;
      lcr_reg <= 8'h03;
      scr_reg <= 8'h00;
      irq_reg <= 1'b0;
    end else begin
      if (ier_wr) ier_reg <= w_data_reg[1:0];
      if (lcr_wr) lcr_reg <= w_data_reg;
      if (scr_wr) scr_reg <= w_data_reg;
      irq_reg <= (ier_reg[0] && !rx_empty) || (ier_reg[1] && tx_empty);
    end
  end

  assign uart_axi_awready = !aw_held_reg;
  assign uart_axi_wready  = !w_held_reg;
  assign uart_axi_bvalid  = bvalid_reg;
  assign uart_axi_bresp   = bresp_reg;
  assign uart_axi_arready = !rvalid_reg;
  assign uart_axi_rvalid  = rvalid_reg;
  assign uart_axi_rdata   = {24'd0, rdata_reg};
  assign uart_axi_rresp   = rresp_reg;
  assign tx_valid         = !tx_empty;
  assign tx_data          = fifo_head[0];
  assign rx_ready         = !rx_full;
  assign uart_irq         = irq_reg;

  // Only the low data byte and word-aligned address bits carry meaning.
  assign unused_bits = ^{uart_axi_wdata[31:8], aw_addr_reg[1:0], uart_axi_araddr[1:0]};

endmodule

// File: tb/tb_uart_axil_responder.sv
// Self-checking bench: directed scenarios plus randomized register traffic and
// byte streams, compared every cycle against a queue-based register model.
module tb_uart_axil_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [12:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        uart_irq;

  always #5 clk = ~clk;

  uart_axil_responder #(.FIFO_DEPTH(DEPTH), .BASE_BIT(12)) dut (
    .chipset_clk(clk), .chipset_rst(rst),
    .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
    .uart_axi_wdata(wdata), .uart_axi_wvalid(wvalid), .uart_axi_wready(wready),
    .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready),
    .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
    .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid),
    .uart_axi_rready(rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .uart_irq(uart_irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [1:0]  m_ier;
  logic [7:0]  m_lcr;
  logic [7:0]  m_scr;
  logic        m_irq;
  logic        m_irq_n;
  int          m_rx_n;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp;

  // Stimulus-to-model hand-off: the flagged access takes effect at the next edge
  logic        mdl_wr_go = 1'b0;
  logic [12:0] mdl_wr_addr;
  logic [7:0]  mdl_wr_data;
  logic        mdl_rd_go = 1'b0;
  logic [12:0] mdl_rd_addr;
  logic        rand_en = 1'b0;
  logic        cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic is_slverr(input logic [12:0] a);
    logic [2:0] idx;
    idx = a[4:2];
    return !(a[12] && (a[11:5] == 7'd0)) || (idx == 3'd4) || (idx == 3'd6);
  endfunction

  function automatic logic [7:0] model_lsr();
    logic [7:0] v;
    v = (txq.size() == 0) ? 8'h60 : 8'h00;
    if (rxq.size() > 0) v = v | 8'h01;
    return v;
  endfunction

  function automatic logic [7:0] model_iir();
    if (m_ier[0] && rxq.size() > 0) return 8'hC4;
    if (m_ier[1] && txq.size() == 0) return 8'hC2;
    return 8'hC1;
  endfunction

  task automatic model_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'd0;
    r = 2'b00;
    if (is_slverr(a)) r = 2'b10;
    else begin
      case (a[4:2])
        3'd0:    d = (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'd0;
        3'd1:    d = {30'd0, m_ier};
        3'd2:    d = {24'd0, model_iir()};
        3'd3:    d = {24'd0, m_lcr};
        3'd5:    d = {24'd0, model_lsr()};
        3'd7:    d = {24'd0, m_scr};
        default: d = 32'd0;
      endcase
    end
  endtask

  task automatic model_write(input logic [12:0] a, input logic [7:0] d);
    if (!is_slverr(a)) begin
      case (a[4:2])
        3'd0: if (txq.size() < DEPTH) txq.push_back(d);
        3'd1: m_ier = d[1:0];
        3'd2: begin
          if (d[1]) rxq.delete();
          if (d[2]) txq.delete();
        end
        3'd3: m_lcr = d;
        3'd7: m_scr = d;
        default: ;
      endcase
    end
  endtask

  // Model advance at each active edge, using pre-edge state for reads and flags
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        txq.delete();
        rxq.delete();
        m_ier = 2'b00;
        m_lcr = 8'h03;
        m_scr = 8'h00;
        m_irq = 1'b0;
      end else begin
        m_irq_n = (m_ier[0] && rxq.size() > 0) || (m_ier[1] && txq.size() == 0);
        m_rx_n  = rxq.size();
        if (mdl_rd_go) begin
          model_read(mdl_rd_addr, exp_rdata, exp_rresp);
          if (exp_rresp == 2'b00 && mdl_rd_addr[4:2] == 3'd0 && rxq.size() > 0)
            void'(rxq.pop_front());
        end
        if (tx_ready && txq.size() > 0) void'(txq.pop_front());
        if (rx_valid && m_rx_n < DEPTH) rxq.push_back(rx_data);
        // Applied last so an FCR clear overrides same-edge pushes and pops
        if (mdl_wr_go) model_write(mdl_wr_addr, mdl_wr_data);
        m_irq = m_irq_n;
      end
    end
  end

  // Per-cycle compare of the stream side and interrupt
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, txq.size() > 0});
        if (txq.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, txq[0]});
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, rxq.size() < DEPTH});
        chk("uart_irq", {31'd0, uart_irq}, {31'd0, m_irq});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic rx_kick);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("awready_held", {31'd0, awready}, 32'd0);
    chk("wready_held", {31'd0, wready}, 32'd0);
    chk("bvalid_early", {31'd0, bvalid}, 32'd0);
    mdl_wr_go = 1'b1; mdl_wr_addr = a; mdl_wr_data = d[7:0];
    if (rx_kick) begin
      rx_valid = 1'b1;
      rx_data  = 8'h77;
    end
    tick();
    mdl_wr_go = 1'b0;
    if (rx_kick) rx_valid = 1'b0;
    chk("bvalid", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, is_slverr(a) ? 32'd2 : 32'd0);
    tick();
    chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [12:0] a, input int hold,
                         output logic [31:0] got, output logic [1:0] gresp);
    araddr = a; arvalid = 1'b1;
    rready = (hold == 0);
    mdl_rd_go = 1'b1; mdl_rd_addr = a;
    tick();
    arvalid = 1'b0; mdl_rd_go = 1'b0;
    got = rdata; gresp = rresp;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk("rdata", rdata, exp_rdata);
    chk("rresp", {30'd0, rresp}, {30'd0, exp_rresp});
    chk("arready_busy", {31'd0, arready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("rdata_hold", rdata, got);
    end
    rready = 1'b1;
    tick();
    chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  logic [12:0] addr_tab [10];
  logic [31:0] rd_v;
  logic [1:0]  rd_r;
  int          n_out;

  initial begin
    addr_tab = '{13'h1000, 13'h1004, 13'h1008, 13'h100C, 13'h1010,
                 13'h1014, 13'h1018, 13'h101C, 13'h0000, 13'h1020};
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_irq", {31'd0, uart_irq}, 32'd0);
    cmp_en = 1'b1;
    tick();

    do_read(13'h1014, 0, rd_v, rd_r);
    chk("lsr_reset_lit", rd_v, 32'h60);
    do_read(13'h100C, 0, rd_v, rd_r);
    chk("lcr_reset_lit", rd_v, 32'h03);

    do_write(13'h1000, 32'h41, 1'b0);
    chk("thr_tx_valid_lit", {31'd0, tx_valid}, 32'd1);
    chk("thr_tx_data_lit", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_drain_lit", {31'd0, tx_valid}, 32'd0);
    do_read(13'h1014, 0, rd_v, rd_r);
    chk("lsr_after_tx_lit", rd_v, 32'h60);

    // W leads AW by three cycles while B is back-pressured
    bready = 1'b0;
    wdata = 32'hA5; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("w_only_wready", {31'd0, wready}, 32'd0);
      chk("w_only_awready", {31'd0, awready}, 32'd1);
      tick();
    end
    awaddr = 13'h101C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_late_awready", {31'd0, awready}, 32'd0);
    chk("aw_late_bvalid", {31'd0, bvalid}, 32'd0);
    mdl_wr_go = 1'b1; mdl_wr_addr = 13'h101C; mdl_wr_data = 8'hA5;
    tick();
    mdl_wr_go = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("b_held", {31'd0, bvalid}, 32'd1);
      tick();
    end
    bready = 1'b1;
    chk("b_held_resp", {30'd0, bresp}, 32'd0);
    tick();
    chk("b_single", {31'd0, bvalid}, 32'd0);
    tick();
    chk("b_single2", {31'd0, bvalid}, 32'd0);
    do_read(13'h101C, 2, rd_v, rd_r);
    chk("scr_lit", rd_v, 32'hA5);

    for (int i = 0; i < 17; i++) do_write(13'h1000, 32'h80 + i, 1'b0);
    chk("txq_model_full_lit", txq.size(), 32'd16);
    n_out = 0;
    tx_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid) begin
        chk("tx_order_lit", {24'd0, tx_data}, 32'h80 + n_out);
        n_out++;
      end
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_count_lit", n_out, 32'd16);

    do_write(13'h1004, 32'h01, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("irq_rx_lit", {31'd0, uart_irq}, 32'd1);
    do_read(13'h1008, 0, rd_v, rd_r);
    chk("iir_c4_lit", rd_v, 32'hC4);
    do_read(13'h1000, 0, rd_v, rd_r);
    chk("rbr1_lit", rd_v, 32'h11);
    do_read(13'h1000, 0, rd_v, rd_r);
    chk("rbr2_lit", rd_v, 32'h22);
    do_read(13'h1000, 0, rd_v, rd_r);
    chk("rbr_empty_lit", rd_v, 32'h00);
    chk("rbr_empty_resp_lit", {30'd0, rd_r}, 32'd0);
    tick();
    chk("irq_clear_lit", {31'd0, uart_irq}, 32'd0);
    do_read(13'h1008, 0, rd_v, rd_r);
    chk("iir_c1_lit", rd_v, 32'hC1);

    do_read(13'h0000, 0, rd_v, rd_r);
    chk("unmapped_resp_lit", {30'd0, rd_r}, 32'd2);
    chk("unmapped_data_lit", rd_v, 32'd0);
    do_read(13'h1010, 0, rd_v, rd_r);
    chk("idx4_resp_lit", {30'd0, rd_r}, 32'd2);
    do_write(13'h0000, 32'hFF, 1'b0);
    do_write(13'h1010, 32'hFF, 1'b0);
    do_write(13'h1014, 32'hFF, 1'b0);
    do_read(13'h101C, 0, rd_v, rd_r);
    chk("scr_kept_lit", rd_v, 32'hA5);

    do_write(13'h1000, 32'h55, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h66;
    tick();
    rx_valid = 1'b0;
    do_read(13'h1014, 0, rd_v, rd_r);
    chk("lsr_both_lit", rd_v, 32'h01);
    do_write(13'h1008, 32'h06, 1'b1);
    do_read(13'h1014, 0, rd_v, rd_r);
    chk("lsr_fcr_clear_lit", rd_v, 32'h60);

    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [12:0] a;
      a = addr_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 1'b0);
      else do_read(a, $urandom_range(0, 2), rd_v, rd_r);
    end
    rand_en = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    tick();

    // Reset with an address beat held and TX occupied drops everything
    do_write(13'h1000, 32'h99, 1'b0);
    awaddr = 13'h1004; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("pre_rst_awready", {31'd0, awready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_awready", {31'd0, awready}, 32'd1);
    chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    wdata = 32'h12; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    tick();
    chk("post_rst_no_b", {31'd0, bvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_axil_responder.md
Name: uart_axil_responder

Overview:
- AXI4-Lite responder terminating the chipset's 13-bit-address / 32-bit-data UART register port.
- Implements a 16550-style register subset at base 0x1000, stride 4.
- Has TX and RX byte FIFOs, exchanged with a serializer core over valid/ready byte streams.
- Drives the level-sensitive uart_irq back to the chipset.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO (power of 2, ≥2).
- BASE_BIT, 12, address bit that must be 1 for a mapped access.

Ports:
- chipset_clk, in, 1, sole clock.
- chipset_rst, in, 1, synchronous active-high reset.
- uart_axi_awaddr in 13, uart_axi_awvalid in 1, uart_axi_awready out 1: write address channel.
- uart_axi_wdata in 32, uart_axi_wvalid in 1, uart_axi_wready out 1: write data channel. No wstrb; only bits [7:0] are significant.
- uart_axi_bresp out 2, uart_axi_bvalid out 1, uart_axi_bready in 1: write response channel.
- uart_axi_araddr in 13, uart_axi_arvalid in 1, uart_axi_arready out 1: read address channel.
- uart_axi_rdata out 32, uart_axi_rresp out 2, uart_axi_rvalid out 1, uart_axi_rready in 1: read data channel.
- tx_data out 8, tx_valid out 1, tx_ready in 1: TX FIFO head to the serializer.
- rx_data in 8, rx_valid in 1, rx_ready out 1: received bytes into the RX FIFO.
- uart_irq, out, 1, interrupt.

Behaviour:
- Reset values:
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - awready=1, wready=1, arready=1.
  - tx_valid=0, rx_ready=1, uart_irq=0.
  - Both FIFOs empty; IER=0, LCR=0x03, SCR=0.
  - Reset mid-transaction drops all held and pending beats.
- Register map (idx = addr[4:2]; mapped only when addr[BASE_BIT]=1 and addr[11:5]=0):
  - 0: read RBR (pops RX) / write THR (pushes TX).
  - 1: IER; bit0 ERBFI, bit1 ETBEI; other bits read 0.
  - 2: read IIR / write FCR.
  - 3: LCR, 8-bit storage only.
  - 5: LSR, read-only; writes return OKAY and are ignored.
  - 7: SCR, 8-bit scratch.
  - idx 4, 6, or unmapped: SLVERR (2'b10); write ignored, read data 0.
- Write path:
  - AW and W are accepted independently into holding registers.
  - awready = !aw_held; wready = !w_held.
  - The cycle both are held and bvalid=0: perform the write, set bvalid=1 next cycle, clear both holds.
  - bvalid stays high until bready. Holds may refill while B is pending, but no second write executes until B completes.
  - Write latency with AW+W in the same cycle: bvalid on cycle +2.
- Read path:
  - arready = !rvalid.
  - On AR handshake: rdata/rresp registered; rvalid=1 next cycle (latency 1).
  - rdata and rresp stay stable until rready.
  - RBR read pops RX at the AR handshake. Empty RX returns 0, no pop, OKAY.
- Read data formats:
  - rdata[31:8]=0 always.
  - LSR = {1'b0, TEMT, THRE, 4'b0, DR}: DR = RX non-empty; THRE = TEMT = TX empty.
  - IIR = 0xC4 if IER[0]&DR; else 0xC2 if IER[1]&THRE; else 0xC1.
- FIFOs:
  - Ordinary pointer FIFOs with wrap-around; count is $clog2(FIFO_DEPTH)+1 bits.
  - tx_valid = TX non-empty; tx_data = TX head; pop on tx_valid&tx_ready.
  - rx_ready = RX not full; push on rx_valid&rx_ready.
  - THR write into a full TX FIFO: byte dropped, bresp OKAY.
  - Push and pop in the same cycle: count unchanged; allowed when full (TX pop frees a slot) and when empty-for-pop is false.
  - FCR write: bit1 clears RX, bit2 clears TX. Clear wins over any same-cycle push/pop on that FIFO.
- Interrupt: uart_irq is registered, (IER[0]&DR)|(IER[1]&THRE), and lags state by 1 cycle. Level-sensitive; not cleared by the IIR read.

Test Plan:
- Reset, then idle → uart_irq=0; all ready outputs match reset values. Read 0x1014 → rdata=0x60, rresp=0, rvalid 1 cycle after arvalid handshake.
- AW 0x1000 with W 0x41, same cycle → bvalid at +2, bresp=0; tx_valid=1, tx_data=0x41. tx_ready=1 → tx_valid drops; LSR=0x60.
- W presented 3 cycles before AW (0x101C, 0xA5) with bready held low 4 cycles → single B; awready/wready low while held. Read 0x101C → 0xA5.
- 17 THR writes with tx_ready=0, FIFO_DEPTH=16 → 16 bytes emerge in order; 17th dropped, bresp=0.
- IER=0x01; inject rx bytes 0x11, 0x22 → uart_irq=1, IIR=0xC4. RBR reads → 0x11 then 0x22; third read → 0; uart_irq=0 and IIR=0xC1 after the last pop.
- Access 0x0000 and 0x1010 → SLVERR, rdata=0, no state change. FCR=0x06 written in the same cycle as an rx push → both FIFOs empty.
